// File: rtl/cpu_mem_bridge_if.sv
// Bus interfaces for cpu_mem_bridge: CPU-side request/response channels and memory-side channels.
// The master modport is the side that issues requests on that bus.

interface cpu_bus_if;
  logic [31:0] PC;
  logic        Inst_Req_Valid;
  logic        Inst_Req_Ready;
  logic [31:0] Instruction;
  logic        Inst_Valid;
  logic        Inst_Ready;
  logic [31:0] Address;
  logic        MemWrite;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        MemRead;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready;

  modport master (
    output PC, Inst_Req_Valid, Inst_Ready,
    output Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
    input  Inst_Req_Ready, Instruction, Inst_Valid,
    input  Mem_Req_Ready, Read_data, Read_data_Valid
  );

  modport slave (
    input  PC, Inst_Req_Valid, Inst_Ready,
    input  Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
    output Inst_Req_Ready, Instruction, Inst_Valid,
    output Mem_Req_Ready, Read_data, Read_data_Valid
  );
endinterface

interface mem_bus_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_ready;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb, mem_rsp_ready,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb, mem_rsp_ready,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );
endinterface

// File: rtl/cpu_mem_bridge.sv
// Single-outstanding bridge from CPU fetch/load/store requests to a valid/ready memory port.
// All outputs are registered, computed from the next state so they line up with the state register.

module cpu_mem_bridge #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  cpu_bus_if.slave         cpu,
  mem_bus_if.master        mem,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IREQ = 3'd1,
    S_IRSP = 3'd2,
    S_IOUT = 3'd3,
    S_RREQ = 3'd4,
    S_RRSP = 3'd5,
    S_ROUT = 3'd6,
    S_WREQ = 3'd7
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0]      r_addr,  w_addr_nxt;
  logic [31:0]      r_wdata, w_wdata_nxt;
  logic [3:0]       r_wstrb, w_wstrb_nxt;
  logic [31:0]      r_data,  w_data_nxt;
  logic [31:0]      r_instr, w_instr_nxt;
  logic [31:0]      r_rdata, w_rdata_nxt;
  logic             r_req_ready,   w_req_ready_nxt;
  logic             r_req_valid,   w_req_valid_nxt;
  logic             r_req_wen,     w_req_wen_nxt;
  logic [3:0]       r_req_wstrb,   w_req_wstrb_nxt;
  logic             r_rsp_ready,   w_rsp_ready_nxt;
  logic             r_inst_valid,  w_inst_valid_nxt;
  logic             r_rdata_valid, w_rdata_valid_nxt;
  logic [CNT_W-1:0] r_stall;
  logic             w_accept;

  // Requests are only taken once the ready outputs are actually showing 1
  assign w_accept = (r_state == S_IDLE) && r_req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (cpu.MemWrite)            w_state_nxt = S_WREQ;
          else if (cpu.MemRead)        w_state_nxt = S_RREQ;
          else if (cpu.Inst_Req_Valid) w_state_nxt = S_IREQ;
        end
      end
      S_IREQ: if (mem.mem_req_ready)   w_state_nxt = S_IRSP;
      S_RREQ: if (mem.mem_req_ready)   w_state_nxt = S_RRSP;
      S_WREQ: if (mem.mem_req_ready)   w_state_nxt = S_IDLE;
      S_IRSP: if (mem.mem_rsp_valid)   w_state_nxt = S_IOUT;
      S_RRSP: if (mem.mem_rsp_valid)   w_state_nxt = S_ROUT;
      S_IOUT: if (cpu.Inst_Ready)      w_state_nxt = S_IDLE;
      S_ROUT: if (cpu.Read_data_Ready) w_state_nxt = S_IDLE;
      default:                         w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_wstrb_nxt = r_wstrb;
    w_data_nxt  = r_data;
    w_instr_nxt = r_instr;
    w_rdata_nxt = r_rdata;
    if (w_accept) begin
      if (cpu.MemWrite) begin
        w_addr_nxt  = cpu.Address;
        w_wdata_nxt = cpu.Write_data;
        w_wstrb_nxt = cpu.Write_strb;
      end else if (cpu.MemRead) begin
        w_addr_nxt  = cpu.Address;
      end else if (cpu.Inst_Req_Valid) begin
        w_addr_nxt  = cpu.PC;
      end
    end
    // Responses are captured only while waiting for one; stray valids are dropped
    if ((r_state == S_IRSP) && mem.mem_rsp_valid) begin
      w_data_nxt  = mem.mem_rsp_data;
      w_instr_nxt = mem.mem_rsp_data;
    end
    if ((r_state == S_RRSP) && mem.mem_rsp_valid) begin
      w_data_nxt  = mem.mem_rsp_data;
      w_rdata_nxt = mem.mem_rsp_data;
    end
    w_req_ready_nxt   = (w_state_nxt == S_IDLE);
    w_req_valid_nxt   = (w_state_nxt == S_IREQ) || (w_state_nxt == S_RREQ) || (w_state_nxt == S_WREQ);
    w_req_wen_nxt     = (w_state_nxt == S_WREQ);
    w_req_wstrb_nxt   = (w_state_nxt == S_WREQ) ? w_wstrb_nxt : 4'b0000;
    w_rsp_ready_nxt   = (w_state_nxt == S_IRSP) || (w_state_nxt == S_RRSP);
    w_inst_valid_nxt  = (w_state_nxt == S_IOUT);
    w_rdata_valid_nxt = (w_state_nxt == S_ROUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_data        <= '0;
      r_instr       <= '0;
      r_rdata       <= '0;
      r_req_ready   <= 1'b0;
      r_req_valid   <= 1'b0;
      r_req_wen     <= 1'b0;
      r_req_wstrb   <= '0;
      r_rsp_ready   <= 1'b0;
      r_inst_valid  <= 1'b0;
      r_rdata_valid <= 1'b0;
      r_stall       <= '0;
    end else begin
      r_addr        <= w_addr_nxt;
      r_wdata       <= w_wdata_nxt;
      r_wstrb       <= w_wstrb_nxt;
      r_data        <= w_data_nxt;
      r_instr       <= w_instr_nxt;
      r_rdata       <= w_rdata_nxt;
      r_req_ready   <= w_req_ready_nxt;
      r_req_valid   <= w_req_valid_nxt;
      r_req_wen     <= w_req_wen_nxt;
      r_req_wstrb   <= w_req_wstrb_nxt;
      r_rsp_ready   <= w_rsp_ready_nxt;
      r_inst_valid  <= w_inst_valid_nxt;
      r_rdata_valid <= w_rdata_valid_nxt;
      if (r_state != S_IDLE) r_stall <= r_stall + CNT_W'(1);
    end
  end

  assign cpu.Inst_Req_Ready  = r_req_ready;
  assign cpu.Mem_Req_Ready   = r_req_ready;
  assign cpu.Instruction     = r_instr;
  assign cpu.Inst_Valid      = r_inst_valid;
  assign cpu.Read_data       = r_rdata;
  assign cpu.Read_data_Valid = r_rdata_valid;

  assign mem.mem_req_valid   = r_req_valid;
  assign mem.mem_req_addr    = r_addr;
  assign mem.mem_req_wen     = r_req_wen;
  assign mem.mem_req_wdata   = r_wdata;
  assign mem.mem_req_wstrb   = r_req_wstrb;
  assign mem.mem_rsp_ready   = r_rsp_ready;

  assign stall_cycles        = r_stall;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Directed self-checking bench for cpu_mem_bridge: fetch, write, read, priority, reset and spurious-response cases.

module tb_cpu_mem_bridge;

  logic        clk;
  logic        rst;
  logic [31:0] stall_cycles;
  int          n_checks;
  int          n_errors;

  cpu_bus_if u_cpu ();
  mem_bus_if u_mem ();

  cpu_mem_bridge #(.CNT_W(32)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .cpu          (u_cpu),
    .mem          (u_mem),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Fetch with memory ready and response on first opportunity; Inst_Valid 3 cycles after acceptance
  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] ins);
    check("fetch_idle_rdy", 72'(u_cpu.Inst_Req_Ready), 72'(1));
    u_cpu.PC = pc;
    u_cpu.Inst_Req_Valid = 1'b1;
    u_mem.mem_req_ready = 1'b1;
    tick();
    u_cpu.Inst_Req_Valid = 1'b0;
    check("fetch_req", 72'({u_mem.mem_req_valid, u_mem.mem_req_wen, u_mem.mem_req_wstrb, u_mem.mem_req_addr,
                            u_cpu.Inst_Req_Ready, u_cpu.Inst_Valid}),
          72'({1'b1, 1'b0, 4'b0000, pc, 1'b0, 1'b0}));
    u_mem.mem_rsp_valid = 1'b1;
    u_mem.mem_rsp_data = ins;
    tick();
    check("fetch_irsp", 72'({u_cpu.Inst_Valid, u_mem.mem_rsp_ready, u_mem.mem_req_valid}), 72'(3'b010));
    tick();
    check("fetch_out", 72'({u_cpu.Inst_Valid, u_cpu.Instruction}), 72'({1'b1, ins}));
    u_mem.mem_rsp_valid = 1'b0;
    u_mem.mem_req_ready = 1'b0;
    u_cpu.Inst_Ready = 1'b1;
    tick();
    u_cpu.Inst_Ready = 1'b0;
    check("fetch_done", 72'({u_cpu.Inst_Valid, u_cpu.Inst_Req_Ready, u_cpu.Instruction}), 72'({1'b0, 1'b1, ins}));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    u_cpu.PC = '0;
    u_cpu.Inst_Req_Valid = 1'b0;
    u_cpu.Inst_Ready = 1'b0;
    u_cpu.Address = '0;
    u_cpu.MemWrite = 1'b0;
    u_cpu.Write_data = '0;
    u_cpu.Write_strb = '0;
    u_cpu.MemRead = 1'b0;
    u_cpu.Read_data_Ready = 1'b0;
    u_mem.mem_req_ready = 1'b0;
    u_mem.mem_rsp_valid = 1'b0;
    u_mem.mem_rsp_data = '0;

    // Reset state
    tick();
    tick();
    check("rst_ctrl", 72'({u_cpu.Inst_Req_Ready, u_cpu.Mem_Req_Ready, u_mem.mem_req_valid, u_mem.mem_req_wen,
                           u_mem.mem_req_wstrb, u_mem.mem_rsp_ready, u_cpu.Inst_Valid, u_cpu.Read_data_Valid}),
          72'(0));
    check("rst_data", 72'({u_cpu.Instruction, u_cpu.Read_data}), 72'(0));
    check("rst_addr", 72'({u_mem.mem_req_addr, u_mem.mem_req_wdata}), 72'(0));
    check("rst_stall", 72'(stall_cycles), 72'(0));
    rst = 1'b0;
    tick();

    // Basic fetch
    do_fetch(32'h0000_0010, 32'h0000_0013);
    check("fetch_stall", 72'(stall_cycles), 72'(3));

    // Write with 5 cycles of memory backpressure
    do_reset();
    u_cpu.Address = 32'h0000_0100;
    u_cpu.Write_data = 32'hDEAD_BEEF;
    u_cpu.Write_strb = 4'b0011;
    u_cpu.MemWrite = 1'b1;
    u_mem.mem_req_ready = 1'b0;
    tick();
    u_cpu.MemWrite = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("wr_hold", 72'({u_mem.mem_req_valid, u_mem.mem_req_wen, u_mem.mem_req_wstrb,
                            u_mem.mem_req_addr[1:0] == 2'b00 ? u_mem.mem_req_addr : 32'hFFFF_FFFF, u_mem.mem_req_wdata}),
            72'({1'b1, 1'b1, 4'b0011, 32'h0000_0100, 32'hDEAD_BEEF}));
      if (i == 5) u_mem.mem_req_ready = 1'b1;
      tick();
    end
    u_mem.mem_req_ready = 1'b0;
    check("wr_done", 72'({u_mem.mem_req_valid, u_mem.mem_req_wen, u_mem.mem_req_wstrb, u_cpu.Mem_Req_Ready}),
          72'(7'b0000001));
    check("wr_stall", 72'(stall_cycles), 72'(6));

    // Read with response-side backpressure
    u_cpu.Address = 32'h0000_0200;
    u_cpu.MemRead = 1'b1;
    u_mem.mem_req_ready = 1'b1;
    tick();
    u_cpu.MemRead = 1'b0;
    check("rd_req", 72'({u_mem.mem_req_valid, u_mem.mem_req_wen, u_mem.mem_req_wstrb, u_mem.mem_req_addr}),
          72'({1'b1, 1'b0, 4'b0000, 32'h0000_0200}));
    tick();
    check("rd_rsp_rdy", 72'({u_mem.mem_rsp_ready, u_mem.mem_req_valid}), 72'(2'b10));
    u_mem.mem_rsp_valid = 1'b1;
    u_mem.mem_rsp_data = 32'h1234_5678;
    tick();
    u_mem.mem_rsp_valid = 1'b0;
    u_mem.mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rd_hold", 72'({u_cpu.Read_data_Valid, u_cpu.Read_data}), 72'({1'b1, 32'h1234_5678}));
      tick();
    end
    u_cpu.Read_data_Ready = 1'b1;
    tick();
    u_cpu.Read_data_Ready = 1'b0;
    check("rd_done", 72'({u_cpu.Read_data_Valid, u_cpu.Mem_Req_Ready, u_cpu.Read_data}),
          72'({1'b0, 1'b1, 32'h1234_5678}));
    check("rd_instr_kept", 72'(u_cpu.Instruction), 72'(0));

    // Read wins over a simultaneous fetch; fetch waits until the read completes
    u_cpu.Address = 32'h0000_0300;
    u_cpu.MemRead = 1'b1;
    u_cpu.PC = 32'h0000_0040;
    u_cpu.Inst_Req_Valid = 1'b1;
    u_mem.mem_req_ready = 1'b1;
    tick();
    u_cpu.MemRead = 1'b0;
    check("prio_rd_first", 72'({u_mem.mem_req_valid, u_mem.mem_req_addr}), 72'({1'b1, 32'h0000_0300}));
    tick();
    u_mem.mem_rsp_valid = 1'b1;
    u_mem.mem_rsp_data = 32'hAAAA_5555;
    tick();
    u_mem.mem_rsp_valid = 1'b0;
    check("prio_rd_out", 72'({u_cpu.Read_data_Valid, u_cpu.Inst_Req_Ready, u_cpu.Read_data}),
          72'({1'b1, 1'b0, 32'hAAAA_5555}));
    u_cpu.Read_data_Ready = 1'b1;
    tick();
    u_cpu.Read_data_Ready = 1'b0;
    u_cpu.Inst_Req_Valid = 1'b0;
    check("prio_idle", 72'({u_cpu.Inst_Req_Ready, u_mem.mem_req_valid}), 72'(2'b10));
    do_fetch(32'h0000_0040, 32'h0000_0055);
    check("prio_rdata_kept", 72'(u_cpu.Read_data), 72'(32'hAAAA_5555));

    // Reset pulsed while waiting for an instruction response
    u_cpu.PC = 32'h0000_0080;
    u_cpu.Inst_Req_Valid = 1'b1;
    u_mem.mem_req_ready = 1'b1;
    tick();
    u_cpu.Inst_Req_Valid = 1'b0;
    tick();
    check("irsp_reached", 72'(u_mem.mem_rsp_ready), 72'(1));
    #1 rst = 1'b1;
    #1;
    check("async_rst_ctrl", 72'({u_mem.mem_rsp_ready, u_mem.mem_req_valid, u_cpu.Inst_Valid,
                                 u_cpu.Inst_Req_Ready, u_cpu.Mem_Req_Ready, u_cpu.Read_data_Valid}), 72'(0));
    check("async_rst_data", 72'({u_cpu.Instruction, u_cpu.Read_data}), 72'(0));
    check("async_rst_stall", 72'({u_mem.mem_req_addr, stall_cycles}), 72'(0));
    u_mem.mem_rsp_valid = 1'b1;
    u_mem.mem_rsp_data = 32'h0000_0BAD;
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("late_rsp_ignored", 72'({u_cpu.Inst_Valid, u_cpu.Inst_Req_Ready, u_mem.mem_rsp_ready, u_cpu.Instruction}),
          72'({1'b0, 1'b1, 1'b0, 32'h0}));
    u_mem.mem_rsp_valid = 1'b0;
    do_fetch(32'h0000_0090, 32'h00A0_0093);

    // Spurious memory response while idle
    u_mem.mem_rsp_valid = 1'b1;
    u_mem.mem_rsp_data = 32'hFFFF_0000;
    tick();
    tick();
    u_mem.mem_rsp_valid = 1'b0;
    check("spur_state", 72'({u_cpu.Inst_Req_Ready, u_mem.mem_req_valid, u_mem.mem_rsp_ready,
                             u_cpu.Inst_Valid, u_cpu.Read_data_Valid}), 72'(5'b10000));
    check("spur_data", 72'({u_cpu.Instruction, u_cpu.Read_data}), 72'({32'h00A0_0093, 32'h0}));
    check("spur_stall", 72'(stall_cycles), 72'(3));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_mem_bridge.md
CPU_MEM_BRIDGE -- requirements
Module: cpu_mem_bridge

Interface
REQ-001 SHALL have parameter CNT_W, default 32, the width of the stall-cycle counter.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have CPU instruction-request ports: PC in 32; Inst_Req_Valid in 1; Inst_Req_Ready out 1.
REQ-005 SHALL have CPU instruction-response ports: Instruction out 32; Inst_Valid out 1; Inst_Ready in 1.
REQ-006 SHALL have CPU data-request ports: Address in 32; MemWrite in 1; Write_data in 32; Write_strb in 4; MemRead in 1; Mem_Req_Ready out 1.
REQ-007 SHALL have CPU data-response ports: Read_data out 32; Read_data_Valid out 1; Read_data_Ready in 1.
REQ-008 SHALL have memory request ports: mem_req_valid out 1; mem_req_ready in 1; mem_req_addr out 32; mem_req_wen out 1; mem_req_wdata out 32; mem_req_wstrb out 4.
REQ-009 SHALL have memory response ports: mem_rsp_valid in 1; mem_rsp_data in 32; mem_rsp_ready out 1.
REQ-010 SHALL have port stall_cycles, output, CNT_W bits: count of cycles spent outside IDLE.

Function
REQ-011 SHALL implement an FSM with states IDLE, IREQ, IRSP, IOUT, RREQ, RRSP, ROUT and WREQ.
REQ-012 Inst_Req_Ready and Mem_Req_Ready SHALL be 1 only in IDLE; elsewhere both are 0.
REQ-013 In IDLE, a CPU request whose valid is high is accepted in the same cycle; priority is MemWrite, then MemRead, then Inst_Req_Valid. A lower-priority request left pending SHALL wait.
REQ-014 On acceptance, the bridge SHALL latch the address into an internal register: PC for fetch, Address for data. Write_data and Write_strb SHALL also be latched for writes.
REQ-015 Acceptance transitions: write -> WREQ; read -> RREQ; fetch -> IREQ.
REQ-016 In IREQ, RREQ and WREQ, mem_req_valid=1 with the latched fields held stable. mem_req_wen=1 only in WREQ; mem_req_wstrb=0 for reads.
REQ-017 When mem_req_valid & mem_req_ready: IREQ -> IRSP, RREQ -> RRSP, WREQ -> IDLE. A write SHALL be complete at that handshake; it has no response.
REQ-018 mem_rsp_ready SHALL be 1 only in IRSP and RRSP.
REQ-019 On mem_rsp_valid in IRSP/RRSP, mem_rsp_data SHALL be latched into a data register. IRSP -> IOUT; RRSP -> ROUT.
REQ-020 In IOUT, Inst_Valid=1 and Instruction=data register. On Inst_Ready the FSM SHALL go to IDLE.
REQ-021 In ROUT, Read_data_Valid=1 and Read_data=data register. On Read_data_Ready the FSM SHALL go to IDLE.
REQ-022 Instruction and Read_data SHALL hold the last latched value outside IOUT/ROUT.
REQ-023 mem_rsp_valid outside IRSP/RRSP SHALL be ignored: no latch, no state change.
REQ-024 Minimum latencies:
  - fetch: 3 cycles from acceptance to Inst_Valid, when mem_req_ready and mem_rsp_valid are each high on first opportunity;
  - write: 1 cycle from acceptance to memory handshake.
REQ-025 Only one transaction SHALL be outstanding at a time; there is no buffering beyond one request.
REQ-026 stall_cycles SHALL increment by 1 every cycle the state is not IDLE. It wraps modulo 2^CNT_W.

Reset
REQ-027 While rst=1, the state SHALL be IDLE and all of the following SHALL be 0:
  - data, address and write registers, and stall_cycles;
  - mem_req_valid, mem_req_wen, mem_req_wstrb, mem_rsp_ready, Inst_Valid and Read_data_Valid;
  - Instruction and Read_data.
  Inst_Req_Ready and Mem_Req_Ready SHALL also be 0 during reset.
REQ-028 Reset asserted mid-transaction SHALL abandon the transaction immediately, with no handshake completed. After release the block SHALL start in IDLE.

Verification
REQ-029 Fetch: PC=0x00000010 with mem_req_ready=1 and mem_rsp_valid=1 one cycle later carrying 0x00000013 -> mem_req_addr=0x10, mem_req_wen=0; Inst_Valid rises 3 cycles after acceptance with Instruction=0x00000013.
REQ-030 Write: Address=0x100, Write_data=0xDEADBEEF, Write_strb=4'b0011, with mem_req_ready held 0 for 5 cycles -> mem_req_valid, wen and fields stable for 6 cycles; then IDLE; stall_cycles=6.
REQ-031 Read with backpressure: mem_rsp_data=0x12345678 and Read_data_Ready held 0 for 4 cycles -> Read_data_Valid stays 1 with Read_data=0x12345678 until Read_data_Ready.
REQ-032 Simultaneous MemRead and Inst_Req_Valid in IDLE -> read issued first. The fetch is accepted only after ROUT returns to IDLE.
REQ-033 rst pulsed while in IRSP -> outputs 0 asynchronously. A subsequent late mem_rsp_valid is ignored. The next fetch completes normally.
REQ-034 Spurious mem_rsp_valid=1 in IDLE -> no state change; Instruction and Read_data unchanged.
